mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter NB_DATA, default 32: data path width in bits.
REQ-002 Parameter NB_ADDR, default 5: register-index width.
REQ-003 Parameter MEM_WORDS, default 256: data-memory depth in 32-bit words; SHALL be a power of two.
REQ-004 i_clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-005 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 i_stall  in  1  1 = hold the pipeline register and suppress the memory write.
REQ-007 i_ALUresult  in  NB_DATA  byte address for loads and stores; pass-through value for ALU ops.
REQ-008 i_data2write  in  NB_DATA  store data (rt).
REQ-009 i_reg2write  in  NB_ADDR  destination register.
REQ-010 i_memRead, i_memWrite, i_mem2reg, i_regWrite  in  1 each  control bits.
REQ-011 i_width  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-012 i_signed  in  1  1 = sign-extend a load, 0 = zero-extend.
REQ-013 o_reg_read  out  NB_DATA  extended load data, registered.
REQ-014 o_ALUresult, o_reg2write, o_mem2reg, o_regWrite  out  registered copies of the inputs.
REQ-015 o_misaligned  out  1  registered flag: the access captured in that cycle was misaligned.

Function
REQ-016 The data memory SHALL be little-endian and byte-addressed; word index = addr[log2(MEM_WORDS)+1:2]; higher address bits SHALL be ignored (wrap modulo 4*MEM_WORDS).
REQ-017 A store (i_memWrite=1, i_stall=0, aligned) SHALL write only the addressed lanes at the rising edge: byte -> lane addr[1:0] gets data[7:0]; half -> lanes {addr[1],0}/{addr[1],1} get data[15:0]; word -> all lanes.
REQ-018 Misaligned: a half access with addr[0]=1, or a word access with addr[1:0]!=0; the store SHALL be suppressed, o_misaligned SHALL be 1 next cycle, and o_regWrite SHALL be forced to 0 for that access.
REQ-019 A load SHALL read the addressed word combinationally, extract the lane per i_width/addr, extend per i_signed, and register the result into o_reg_read; latency is 1 clock.
REQ-020 When i_memRead=0, o_reg_read SHALL capture 0.
REQ-021 When i_memRead and i_memWrite are both 1, the load SHALL return the pre-write contents (read-before-write).
REQ-022 A load in the cycle after a store to the same word SHALL see the stored data.
REQ-023 With i_stall=1, all outputs SHALL hold their values and memory SHALL NOT be written.

Reset
REQ-024 While i_rst_n=0, all outputs SHALL be 0, asynchronously.
REQ-025 Memory contents SHALL NOT be reset; reset asserted mid-store SHALL have undefined effect only on the word being written.

Configuration
REQ-026 With MEM_STAGE_DEBUG_EN defined, ports i_dbg_addr (in, log2(MEM_WORDS) bits, word index) and o_dbg_data (out, 32 bits, combinational read of that word) SHALL exist for the debug unit; these ports SHALL NOT affect pipeline behaviour.
REQ-027 Without MEM_STAGE_DEBUG_EN, the debug ports and their read mux SHALL be absent.

Structure
REQ-028 Shared package mem_pkg SHALL hold the i_width encodings (WIDTH_BYTE, WIDTH_HALF, WIDTH_WORD) and NB_DATA.
REQ-029 Sub-module data_memory SHALL implement the byte-lane-enabled RAM: 4-bit lane-enable write, asynchronous read, optional debug port.

Verification
REQ-030 Word store 0xDEADBEEF at 0x10, then a word load at 0x10 -> o_reg_read=0xDEADBEEF one cycle after the load.
REQ-031 Byte store 0x80 at 0x13, then a signed byte load at 0x13 -> 0xFFFFFF80; the same load unsigned -> 0x00000080; a word load at 0x10 -> 0x80ADBEEF.
REQ-032 Half store 0x1234 at 0x11 -> o_misaligned=1, o_regWrite=0, and a word load at 0x10 -> 0x80ADBEEF (unchanged).
REQ-033 i_stall=1 during a store of 0x55 at 0x20 -> outputs held, and a later load at 0x20 returns the prior contents.
REQ-034 Assert i_rst_n=0 between clock edges -> all outputs 0 immediately; memory at 0x10 still reads 0x80ADBEEF after reset.
REQ-035 Store at address 0x400 with MEM_WORDS=256 -> word 0 is written (wrap-around), confirmed by a load at 0x0.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings and lane helpers for the memory stage.
// Pure definitions: no latency, no flow control.
package mem_pkg;

    localparam int NB_DATA = 32;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    function automatic logic [3:0] lane_enable(input logic [1:0] width, input logic [1:0] lane);
        logic [3:0] en;
        case (width)
            WIDTH_BYTE: en = 4'b0001 << lane;
            WIDTH_HALF: en = lane[1] ? 4'b1100 : 4'b0011;
            default:    en = 4'b1111;
        endcase
        return en;
    endfunction

    // Reserved width 2'b11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] lane);
        logic mis;
        case (width)
            WIDTH_BYTE: mis = 1'b0;
            WIDTH_HALF: mis = lane[0];
            default:    mis = |lane;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/data_memory.sv
// Byte-lane-enabled word RAM: 4-bit lane-enable write on the rising edge, asynchronous read.
// No flow control; optional debug read port under MEM_STAGE_DEBUG_EN.
module data_memory #(
    parameter int MEM_WORDS = 256
) (
    input  logic                          i_clk,
    input  logic [$clog2(MEM_WORDS)-1:0]  i_addr,
    input  logic [3:0]                    i_we,
    input  logic [31:0]                   i_wdata,
`ifdef MEM_STAGE_DEBUG_EN
    input  logic [$clog2(MEM_WORDS)-1:0]  i_dbg_addr,
    output logic [31:0]                   o_dbg_data,
`endif
    output logic [31:0]                   o_rdata
);

    // Contents are deliberately not reset.
    logic [31:0] r_mem [MEM_WORDS];

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i]) begin
                r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

`ifdef MEM_STAGE_DEBUG_EN
    assign o_dbg_data = r_mem[i_dbg_addr];
`endif

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: little-endian byte-addressed loads/stores, 1-cycle registered outputs.
// i_stall holds all outputs and suppresses the write; debug port under MEM_STAGE_DEBUG_EN.
module mem_stage #(
    parameter int NB_DATA   = mem_pkg::NB_DATA,
    parameter int NB_ADDR   = 5,
    parameter int MEM_WORDS = 256
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_stall,
    input  logic [NB_DATA-1:0]            i_ALUresult,
    input  logic [NB_DATA-1:0]            i_data2write,
    input  logic [NB_ADDR-1:0]            i_reg2write,
    input  logic                          i_memRead,
    input  logic                          i_memWrite,
    input  logic                          i_mem2reg,
    input  logic                          i_regWrite,
    input  logic [1:0]                    i_width,
    input  logic                          i_signed,
`ifdef MEM_STAGE_DEBUG_EN
    input  logic [$clog2(MEM_WORDS)-1:0]  i_dbg_addr,
    output logic [31:0]                   o_dbg_data,
`endif
    output logic [NB_DATA-1:0]            o_reg_read,
    output logic [NB_DATA-1:0]            o_ALUresult,
    output logic [NB_ADDR-1:0]            o_reg2write,
    output logic                          o_mem2reg,
    output logic                          o_regWrite,
    output logic                          o_misaligned
);

    import mem_pkg::*;

    localparam int AW = $clog2(MEM_WORDS);

    logic [1:0]          w_lane;
    logic [AW-1:0]       w_word;
    logic                w_misaligned;
    logic [3:0]          w_we;
    logic [31:0]         w_wdata;
    logic [31:0]         w_rdata;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [NB_DATA-1:0]  w_load;

    logic [NB_DATA-1:0]  r_reg_read;
    logic [NB_DATA-1:0]  r_alu;
    logic [NB_ADDR-1:0]  r_reg2write;
    logic                r_mem2reg;
    logic                r_regWrite;
    logic                r_misaligned;

    // Address bits above the word index are ignored, so the memory wraps.
    assign w_lane       = i_ALUresult[1:0];
    assign w_word       = i_ALUresult[AW+1:2];
    assign w_misaligned = (i_memRead | i_memWrite) & is_misaligned(i_width, w_lane);
    assign w_we         = (i_memWrite & ~i_stall & ~w_misaligned) ? lane_enable(i_width, w_lane) : 4'b0000;

    always_comb begin
        case (i_width)
            WIDTH_BYTE: w_wdata = {4{i_data2write[7:0]}};
            WIDTH_HALF: w_wdata = {2{i_data2write[15:0]}};
            default:    w_wdata = i_data2write[31:0];
        endcase
    end

    data_memory #(
        .MEM_WORDS (MEM_WORDS)
    ) u_data_memory (
        .i_clk      (i_clk),
        .i_addr     (w_word),
        .i_we       (w_we),
        .i_wdata    (w_wdata),
`ifdef MEM_STAGE_DEBUG_EN
        .i_dbg_addr (i_dbg_addr),
        .o_dbg_data (o_dbg_data),
`endif
        .o_rdata    (w_rdata)
    );

    // Read data is the pre-write word, giving read-before-write on a combined access.
    always_comb begin
        w_byte = w_rdata[8*w_lane +: 8];
        w_half = w_lane[1] ? w_rdata[31:16] : w_rdata[15:0];
        case (i_width)
            WIDTH_BYTE: w_load = {{(NB_DATA-8){i_signed & w_byte[7]}}, w_byte};
            WIDTH_HALF: w_load = {{(NB_DATA-16){i_signed & w_half[15]}}, w_half};
            default:    w_load = {{(NB_DATA-32){i_signed & w_rdata[31]}}, w_rdata};
        endcase
        if (!i_memRead || w_misaligned) begin
            w_load = '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_reg_read   <= '0;
            r_alu        <= '0;
            r_reg2write  <= '0;
            r_mem2reg    <= 1'b0;
            r_regWrite   <= 1'b0;
            r_misaligned <= 1'b0;
        end else if (!i_stall) begin
            r_reg_read   <= w_load;
            r_alu        <= i_ALUresult;
            r_reg2write  <= i_reg2write;
            r_mem2reg    <= i_mem2reg;
            r_regWrite   <= i_regWrite & ~w_misaligned;
            r_misaligned <= w_misaligned;
        end
    end

    assign o_reg_read   = r_reg_read;
    assign o_ALUresult  = r_alu;
    assign o_reg2write  = r_reg2write;
    assign o_mem2reg    = r_mem2reg;
    assign o_regWrite   = r_regWrite;
    assign o_misaligned = r_misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a byte-array reference model and per-cycle compare.
module tb_mem_stage;

    localparam int NB_DATA   = 32;
    localparam int NB_ADDR   = 5;
    localparam int MEM_WORDS = 256;
    localparam int NBYTES    = 4 * MEM_WORDS;
    localparam logic [1:0] WB = 2'b00, WH = 2'b01, WW = 2'b10, WR = 2'b11;

    logic                i_clk = 1'b0;
    logic                i_rst_n = 1'b0;
    logic                i_stall = 1'b0;
    logic [NB_DATA-1:0]  i_ALUresult = '0;
    logic [NB_DATA-1:0]  i_data2write = '0;
    logic [NB_ADDR-1:0]  i_reg2write = '0;
    logic                i_memRead = 1'b0;
    logic                i_memWrite = 1'b0;
    logic                i_mem2reg = 1'b0;
    logic                i_regWrite = 1'b0;
    logic [1:0]          i_width = WW;
    logic                i_signed = 1'b0;
    logic [NB_DATA-1:0]  o_reg_read;
    logic [NB_DATA-1:0]  o_ALUresult;
    logic [NB_ADDR-1:0]  o_reg2write;
    logic                o_mem2reg;
    logic                o_regWrite;
    logic                o_misaligned;
`ifdef MEM_STAGE_DEBUG_EN
    logic [7:0]          i_dbg_addr = '0;
    logic [31:0]         o_dbg_data;
`endif

    mem_stage #(
        .NB_DATA   (NB_DATA),
        .NB_ADDR   (NB_ADDR),
        .MEM_WORDS (MEM_WORDS)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_stall      (i_stall),
        .i_ALUresult  (i_ALUresult),
        .i_data2write (i_data2write),
        .i_reg2write  (i_reg2write),
        .i_memRead    (i_memRead),
        .i_memWrite   (i_memWrite),
        .i_mem2reg    (i_mem2reg),
        .i_regWrite   (i_regWrite),
        .i_width      (i_width),
        .i_signed     (i_signed),
`ifdef MEM_STAGE_DEBUG_EN
        .i_dbg_addr   (i_dbg_addr),
        .o_dbg_data   (o_dbg_data),
`endif
        .o_reg_read   (o_reg_read),
        .o_ALUresult  (o_ALUresult),
        .o_reg2write  (o_reg2write),
        .o_mem2reg    (o_mem2reg),
        .o_regWrite   (o_regWrite),
        .o_misaligned (o_misaligned)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: flat byte array plus a per-byte "has been written" flag.
    logic [7:0]  mm [NBYTES];
    bit          kn [NBYTES];
    logic [31:0] e_rd  = '0;
    logic [31:0] e_alu = '0;
    logic [4:0]  e_r2w = '0;
    logic        e_m2r = 1'b0;
    logic        e_rw  = 1'b0;
    logic        e_mis = 1'b0;
    bit          e_known = 1'b1;
    bit          chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_reg_read"}, o_reg_read, 32'h0);
        chk({tag, "_alu"}, o_ALUresult, 32'h0);
        chk({tag, "_reg2write"}, 32'(o_reg2write), 32'h0);
        chk({tag, "_mem2reg"}, 32'(o_mem2reg), 32'h0);
        chk({tag, "_regWrite"}, 32'(o_regWrite), 32'h0);
        chk({tag, "_misaligned"}, 32'(o_misaligned), 32'h0);
    endtask

    always @(negedge i_clk) begin
        if (chk_en) begin
            if (e_known) chk("reg_read", o_reg_read, e_rd);
            chk("alu", o_ALUresult, e_alu);
            chk("reg2write", 32'(o_reg2write), 32'(e_r2w));
            chk("mem2reg", 32'(o_mem2reg), 32'(e_m2r));
            chk("regWrite", 32'(o_regWrite), 32'(e_rw));
            chk("misaligned", 32'(o_misaligned), 32'(e_mis));
        end
    end

    // Drive one cycle; returns 1 time unit after the capturing edge.
    task automatic op(input logic rd, input logic wr, input logic [1:0] w, input logic sg,
                      input logic [31:0] a, input logic [31:0] d, input logic st);
        int          n;
        int          base;
        longint      v;
        logic        mis;
        bit          known;
        logic [31:0] p_rd;
        i_memRead    = rd;
        i_memWrite   = wr;
        i_width      = w;
        i_signed     = sg;
        i_ALUresult  = a;
        i_data2write = d;
        i_stall      = st;
        i_mem2reg    = rd;
        i_regWrite   = 1'b1;
        i_reg2write  = a[6:2] + 5'd3;
        n     = (w == WB) ? 1 : (w == WH) ? 2 : 4;
        base  = int'(a[9:0]);
        mis   = (rd || wr) && (base % n != 0);
        v     = 0;
        known = 1'b1;
        if (rd && !mis) begin
            for (int i = 0; i < n; i++) begin
                v = v | (longint'(mm[base+i]) << (8*i));
                known = known && kn[base+i];
            end
            if (sg && v >= (longint'(1) << (8*n-1))) v = v - (longint'(1) << (8*n));
        end
        p_rd = v[31:0];
        @(posedge i_clk);
        #1;
        if (!st) begin
            e_rd    = p_rd;
            e_known = known;
            e_alu   = a;
            e_r2w   = a[6:2] + 5'd3;
            e_m2r   = rd;
            e_rw    = !mis;
            e_mis   = mis;
            if (wr && !mis) begin
                for (int i = 0; i < n; i++) begin
                    mm[base+i] = d[8*i +: 8];
                    kn[base+i] = 1'b1;
                end
            end
        end
    endtask

    task automatic reset_mid();
        #1 i_rst_n = 1'b0;
        #1 chk_zero("rst_mid");
        e_rd = '0; e_alu = '0; e_r2w = '0; e_m2r = 1'b0; e_rw = 1'b0; e_mis = 1'b0; e_known = 1'b1;
        #1 i_rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < NBYTES; i++) kn[i] = 1'b0;
        #1 chk_zero("rst_init");
        #2 i_rst_n = 1'b1;
        chk_en = 1'b1;

        op(0, 1, WW, 0, 32'h10, 32'hDEADBEEF, 0);
        op(1, 0, WW, 0, 32'h10, 32'h0, 0);
        chk("word_load_10", o_reg_read, 32'hDEADBEEF);

        op(0, 1, WB, 0, 32'h13, 32'h80, 0);
        op(1, 0, WB, 1, 32'h13, 32'h0, 0);
        chk("byte_signed_13", o_reg_read, 32'hFFFFFF80);
        op(1, 0, WB, 0, 32'h13, 32'h0, 0);
        chk("byte_unsigned_13", o_reg_read, 32'h00000080);
        op(1, 0, WW, 0, 32'h10, 32'h0, 0);
        chk("word_after_byte", o_reg_read, 32'h80ADBEEF);

        op(0, 1, WH, 0, 32'h11, 32'h1234, 0);
        chk("half_mis_flag", 32'(o_misaligned), 32'h1);
        chk("half_mis_regWrite", 32'(o_regWrite), 32'h0);
        op(1, 0, WW, 0, 32'h10, 32'h0, 0);
        chk("word_after_mis", o_reg_read, 32'h80ADBEEF);

        op(1, 0, WH, 1, 32'h12, 32'h0, 0);
        chk("half_signed_12", o_reg_read, 32'hFFFF80AD);
        op(1, 0, WH, 0, 32'h10, 32'h0, 0);
        chk("half_unsigned_10", o_reg_read, 32'h0000BEEF);

        op(0, 1, WW, 0, 32'h20, 32'hCAFEF00D, 0);
        op(1, 0, WW, 0, 32'h10, 32'h0, 0);
        op(0, 1, WB, 0, 32'h20, 32'h55, 1);
        op(0, 1, WB, 0, 32'h20, 32'h55, 1);
        chk("stall_hold_alu", o_ALUresult, 32'h10);
        chk("stall_hold_rd", o_reg_read, 32'h80ADBEEF);
        op(1, 0, WW, 0, 32'h20, 32'h0, 0);
        chk("stall_no_write", o_reg_read, 32'hCAFEF00D);

        op(1, 1, WW, 0, 32'h20, 32'h11223344, 0);
        chk("read_before_write", o_reg_read, 32'hCAFEF00D);
        op(1, 0, WR, 0, 32'h20, 32'h0, 0);
        chk("reserved_width_load", o_reg_read, 32'h11223344);
        op(0, 1, WH, 0, 32'h22, 32'h0000BEAD, 0);
        op(1, 0, WW, 0, 32'h20, 32'h0, 0);
        chk("half_store_upper", o_reg_read, 32'hBEAD3344);
        op(1, 0, WW, 0, 32'h21, 32'h0, 0);
        chk("word_load_mis", 32'(o_misaligned), 32'h1);

        op(0, 0, WW, 0, 32'h12345678, 32'h0, 0);
        chk("alu_pass", o_ALUresult, 32'h12345678);
        chk("alu_no_read", o_reg_read, 32'h0);

        reset_mid();
        op(1, 0, WW, 0, 32'h10, 32'h0, 0);
        chk("mem_survives_reset", o_reg_read, 32'h80ADBEEF);

        op(0, 1, WW, 0, 32'h400, 32'hA5A50001, 0);
        op(1, 0, WW, 0, 32'h0, 32'h0, 0);
        chk("wrap_store_0x400", o_reg_read, 32'hA5A50001);

        op(0, 0, WW, 0, 32'h0, 32'h0, 0);
        @(negedge i_clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
